// File: rtl/imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_sequencer
// Purpose  : Sequences a byte-wide single-port instruction memory, assembling
//            the 10-byte Y86-64 fetch window and arbitrating loader writes.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_sequencer #(
  parameter int MEM_BYTES = 1025,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  output logic [7:0]        byte0,
  output logic [71:0]       byte19,
  output logic              imem_err,
  output logic              busy,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_gnt,
  output logic              load_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [ADDR_W:0] C_MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] C_WIN_TAIL  = (ADDR_W+1)'(9);
  localparam logic [3:0]      C_LAST_IDX  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_cnt;
  logic [7:0]        r_shadow0;
  logic [63:0]       r_shadow19;
  logic [ADDR_W-1:0] r_load_addr;
  logic [7:0]        r_load_data;
  logic              r_load_oor;
  logic              w_fetch_oor;
  logic              w_load_oor;

  // One extra bit so a PC near the top of the address space cannot wrap past the check.
  assign w_fetch_oor = ({1'b0, fetch_pc} + C_WIN_TAIL) >= C_MEM_LIMIT;
  assign w_load_oor  = {1'b0, load_addr} >= C_MEM_LIMIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fetch_valid = 1'b0;
    busy        = 1'b1;
    load_gnt    = 1'b0;
    load_err    = 1'b0;
    mem_addr    = '0;
    mem_wen     = 1'b0;
    mem_wdata   = 8'h00;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_req) begin
          w_state_nxt = S_LOAD;
        end else if (fetch_req) begin
          w_state_nxt = w_fetch_oor ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        mem_addr = r_pc + ADDR_W'(r_cnt);
        if (r_cnt == C_LAST_IDX) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        fetch_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        load_gnt = 1'b1;
        load_err = r_load_oor;
        if (!r_load_oor) begin
          mem_wen   = 1'b1;
          mem_addr  = r_load_addr;
          mem_wdata = r_load_data;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Result registers are written on the edge entering DONE, so they are
  // already valid in the fetch_valid cycle and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_cnt       <= 4'd0;
      r_shadow0   <= 8'h00;
      r_shadow19  <= 64'h0;
      r_load_addr <= '0;
      r_load_data <= 8'h00;
      r_load_oor  <= 1'b0;
      byte0       <= 8'h00;
      byte19      <= 72'h0;
      imem_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_req) begin
            r_load_addr <= load_addr;
            r_load_data <= load_data;
            r_load_oor  <= w_load_oor;
          end else if (fetch_req) begin
            r_pc  <= fetch_pc;
            r_cnt <= 4'd0;
            if (w_fetch_oor) begin
              byte0    <= 8'h00;
              byte19   <= 72'h0;
              imem_err <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (r_cnt == 4'd0) begin
            r_shadow0 <= mem_rdata;
          end else begin
            // Bytes 1..9 shift in from the bottom, so pc+1 ends up in the top byte.
            r_shadow19 <= {r_shadow19[55:0], mem_rdata};
          end
          if (r_cnt == C_LAST_IDX) begin
            r_cnt    <= 4'd0;
            byte0    <= r_shadow0;
            byte19   <= {r_shadow19, mem_rdata};
            imem_err <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_sequencer
// Purpose  : Randomized self-checking bench with a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_sequencer;

  localparam int MEM_BYTES = 1025;
  localparam int ADDR_W    = 64;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [63:0] fetch_pc;
  logic        fetch_valid;
  logic [7:0]  byte0;
  logic [71:0] byte19;
  logic        imem_err;
  logic        busy;
  logic        load_req;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic        load_gnt;
  logic        load_err;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem     [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];

  int          errors;
  int          checks;
  int          valid_count;
  logic [63:0] max_addr;

  imem_fetch_sequencer #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid),
    .byte0      (byte0),
    .byte19     (byte19),
    .imem_err   (imem_err),
    .busy       (busy),
    .load_req   (load_req),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_gnt   (load_gnt),
    .load_err   (load_err),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = 8'h00;
    if (mem_addr < 64'(MEM_BYTES)) mem_rdata = mem[int'(mem_addr)];
  end

  always @(posedge clk) begin
    if (mem_wen === 1'b1 && mem_addr < 64'(MEM_BYTES)) mem[int'(mem_addr)] = mem_wdata;
  end

  always @(negedge clk) begin
    if (fetch_valid === 1'b1) valid_count++;
    if (busy === 1'b1 && mem_addr > max_addr) max_addr = mem_addr;
  end

  task automatic do_load(input logic [63:0] a, input logic [7:0] d);
    logic oor;
    oor = (a >= 64'(MEM_BYTES));
    load_addr = a; load_data = d; load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    checks++;
    if (load_gnt !== 1'b1 || load_err !== oor)
      begin errors++; $display("FAIL load_gnt/err addr=%0d: got gnt=%b err=%b exp gnt=1 err=%b", a, load_gnt, load_err, oor); end
    checks++;
    if (mem_wen !== !oor)
      begin errors++; $display("FAIL load_wen addr=%0d: got %b exp %b", a, mem_wen, !oor); end
    if (!oor) begin
      checks++;
      if (mem_addr !== a || mem_wdata !== d)
        begin errors++; $display("FAIL load_bus: got addr=%0d data=%h exp addr=%0d data=%h", mem_addr, mem_wdata, a, d); end
      ref_mem[int'(a)] = d;
    end
    @(posedge clk); #1;
    checks++;
    if (load_gnt !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL load_end: got gnt=%b busy=%b exp 0 0", load_gnt, busy); end
  endtask

  // Caller is IDLE, #1 after an edge; the request is accepted at the next edge.
  task automatic do_fetch(input logic [63:0] pc, input bit poke, input string tag);
    logic        exp_err;
    logic [7:0]  e0;
    logic [71:0] e19;
    int          n;
    bit          seen;
    int          exp_lat;
    exp_err = (({1'b0, pc} + 65'd9) >= 65'(MEM_BYTES));
    e0 = 8'h00; e19 = 72'h0;
    if (!exp_err) begin
      e0 = ref_mem[int'(pc)];
      for (int k = 1; k <= 9; k++) e19 = e19 | (72'(ref_mem[int'(pc) + k]) << (8 * (9 - k)));
    end
    exp_lat = exp_err ? 1 : 11;
    fetch_pc = pc; fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    n = 1; seen = 0;
    while (!seen && n <= 20) begin
      if (fetch_valid === 1'b1) seen = 1;
      else begin
        fetch_req = (poke && n <= 3);
        @(posedge clk); #1;
        n++;
      end
    end
    fetch_req = 1'b0;
    checks++;
    if (!seen || n != exp_lat)
      begin errors++; $display("FAIL %s latency: got seen=%0d cycles=%0d exp %0d", tag, seen, n, exp_lat); end
    checks++;
    if (byte0 !== e0) begin errors++; $display("FAIL %s byte0: got %h exp %h", tag, byte0, e0); end
    checks++;
    if (byte19 !== e19) begin errors++; $display("FAIL %s byte19: got %h exp %h", tag, byte19, e19); end
    checks++;
    if (imem_err !== exp_err) begin errors++; $display("FAIL %s imem_err: got %b exp %b", tag, imem_err, exp_err); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || fetch_valid !== 1'b0 || byte0 !== e0 || imem_err !== exp_err)
      begin errors++; $display("FAIL %s hold: got busy=%b valid=%b byte0=%h err=%b", tag, busy, fetch_valid, byte0, imem_err); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fetch_valid, busy, load_gnt, load_err, mem_wen, imem_err} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b exp 000000", {fetch_valid, busy, load_gnt, load_err, mem_wen, imem_err}); end
    checks++;
    if (byte0 !== 8'h00 || byte19 !== 72'h0 || mem_addr !== 64'h0 || mem_wdata !== 8'h00)
      begin errors++; $display("FAIL reset_data: got byte0=%h byte19=%h addr=%h wdata=%h exp 0", byte0, byte19, mem_addr, mem_wdata); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_then_fetch;
    logic [7:0] prog [0:9];
    prog = '{8'h30, 8'hF4, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) do_load(64'(i), prog[i]);
    do_fetch(64'd0, 0, "prog_pc0");
    checks++;
    if (byte0 !== 8'h30 || byte19 !== 72'hF40E00000000000000)
      begin errors++; $display("FAIL prog_const: got %h %h exp 30 f40e00000000000000", byte0, byte19); end
  endtask

  task automatic test_reset_mid_read;
    int vc;
    fetch_pc = 64'd0; fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || busy !== 1'b0 || mem_addr !== 64'h0 || mem_wen !== 1'b0)
      begin errors++; $display("FAIL midreset_ctrl: got valid=%b busy=%b addr=%h wen=%b", fetch_valid, busy, mem_addr, mem_wen); end
    checks++;
    if (byte0 !== 8'h00 || byte19 !== 72'h0 || imem_err !== 1'b0)
      begin errors++; $display("FAIL midreset_data: got byte0=%h byte19=%h err=%b exp 0", byte0, byte19, imem_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    vc = valid_count;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (valid_count != vc || busy !== 1'b0)
      begin errors++; $display("FAIL midreset_after: got pulses=%0d busy=%b exp 0 0", valid_count - vc, busy); end
  endtask

  task automatic test_boundary;
    max_addr = 64'h0;
    do_fetch(64'(MEM_BYTES - 10), 0, "pc_last_ok");
    do_fetch(64'(MEM_BYTES - 9), 0, "pc_first_err");
    do_fetch(64'hFFFF_FFFF_FFFF_FFFA, 0, "pc_nowrap");
    checks++;
    if (max_addr > 64'(MEM_BYTES - 1))
      begin errors++; $display("FAIL max_addr: got %0d exp <= %0d", max_addr, MEM_BYTES - 1); end
  endtask

  task automatic test_priority;
    logic [63:0] a;
    logic [7:0]  d;
    a = 64'd200;
    d = ~ref_mem[200];
    load_addr = a; load_data = d; load_req = 1'b1;
    fetch_pc = a; fetch_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    checks++;
    if (load_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== a || fetch_valid !== 1'b0)
      begin errors++; $display("FAIL prio_load: got gnt=%b wen=%b addr=%0d valid=%b", load_gnt, mem_wen, mem_addr, fetch_valid); end
    ref_mem[200] = d;
    @(posedge clk); #1;
    checks++;
    if (load_gnt !== 1'b0 || mem_wen !== 1'b0)
      begin errors++; $display("FAIL prio_wen_once: got gnt=%b wen=%b exp 0 0", load_gnt, mem_wen); end
    do_fetch(a, 0, "prio_fetch");
  endtask

  task automatic test_oor_load_and_ignore;
    int vc;
    do_load(64'(MEM_BYTES), 8'hA5);
    vc = valid_count;
    do_fetch(64'd100, 1, "ignore_poke");
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (valid_count - vc != 1)
      begin errors++; $display("FAIL ignore_pulses: got %0d exp 1", valid_count - vc); end
  endtask

  task automatic test_random;
    logic [63:0] pc;
    int          bad;
    for (int it = 0; it < 12; it++) begin
      pc = 64'($urandom_range(0, MEM_BYTES - 1));
      do_load(pc + 64'($urandom_range(0, 9)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) do_load(64'($urandom_range(MEM_BYTES, MEM_BYTES + 50)), 8'($urandom));
      do_fetch(pc, 0, "random");
    end
    bad = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_image: got %0d differing bytes exp 0", bad); end
  endtask

  initial begin
    errors = 0; checks = 0; valid_count = 0; max_addr = 64'h0;
    rst = 1'b1; fetch_req = 1'b0; fetch_pc = 64'h0;
    load_req = 1'b0; load_addr = 64'h0; load_data = 8'h00;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_then_fetch();
    test_reset_mid_read();
    test_boundary();
    test_priority();
    test_oor_load_and_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
